// File: rtl/coin_pkg.sv
// Shared types for the coin acceptor front-end: coin codes and the
// per-sensor channel FSM states.
package coin_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        C5   = 2'b01,
        C10  = 2'b10
    } coin_t;

    typedef enum logic [1:0] {
        REARM,
        IDLE,
        QUAL_HI,
        HELD
    } chan_state_t;

endpackage

// File: rtl/coin_acceptor_if.sv
// Sensor, handshake and status signals between the coin acceptor (slave)
// and the environment that drives the sensors and the accept line (master).
interface coin_acceptor_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    logic                        coin5_raw;
    logic                        coin10_raw;
    logic                        accept;
    logic                        coin5;
    logic                        coin10;
    logic                        reject;
    logic                        jam;
    logic [$clog2(FIFO_DEPTH):0] level;

    modport master (
        output coin5_raw, coin10_raw, accept,
        input  coin5, coin10, reject, jam, level
    );

    modport slave (
        input  coin5_raw, coin10_raw, accept,
        output coin5, coin10, reject, jam, level
    );
endinterface

// File: rtl/coin_debounce.sv
// One sensor channel: 2-flop synchroniser followed by the debounce/one-shot
// FSM. qual_o marks the edge on which an insertion qualifies.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic qual_o
);
    localparam int unsigned      CntW    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic            s;
    chan_state_t     state_q;
    logic [CntW-1:0] cnt_q;

    assign s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REARM;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                REARM: begin
                    if (s) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                IDLE: begin
                    if (s) begin
                        state_q <= QUAL_HI;
                        cnt_q   <= CntW'(1);
                    end
                end
                QUAL_HI: begin
                    if (!s) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CntLast) begin
                        state_q <= HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                HELD: begin
                    // Count restarts at zero so two events are >= 2*N+1 cycles apart.
                    if (!s) begin
                        state_q <= REARM;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= REARM;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Decoded purely from flops, so glitch-free; the push lands on the
    // same edge that moves the channel into HELD.
    assign qual_o = (state_q == QUAL_HI) && s && (cnt_q == CntLast);

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor top: debounces both sensors, arbitrates jams, buffers coins
// in a FIFO and releases them as single-cycle pulses while accept is high.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input logic           clk,
    input logic           rst_n,
    coin_acceptor_if.slave bus
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    logic            qual5, qual10;
    logic            push_req, full, pop, do_push;
    coin_t           push_type, head;
    coin_t           mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0] count_q, count_d;
    logic            reject_q, reject_d, jam_q, jam_d;

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb5 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (bus.coin5_raw),
        .qual_o (qual5)
    );

    coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb10 (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (bus.coin10_raw),
        .qual_o (qual10)
    );

    always_comb begin
        push_req  = qual5 ^ qual10;
        push_type = qual5 ? C5 : C10;
        full      = (count_q == LvlW'(FIFO_DEPTH));
        pop       = bus.accept && (count_q != '0);
        // A pop on the same edge frees the slot the new coin needs.
        do_push   = push_req && (!full || pop);
        reject_d  = push_req && full && !pop;
        jam_d     = qual5 && qual10;
        wr_ptr_d  = do_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d   = count_q + LvlW'(do_push) - LvlW'(pop);
        head      = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            reject_q <= 1'b0;
            jam_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            reject_q <= reject_d;
            jam_q    <= jam_d;
        end
    end

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_type;
        end
    end

    assign bus.coin5  = pop && (head == C5);
    assign bus.coin10 = pop && (head == C10);
    assign bus.reject = reject_q;
    assign bus.jam    = jam_q;
    assign bus.level  = count_q;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

- Front-end stage between the coin-mechanism sensors and the vending-machine FSM.
- Synchronises and debounces the two raw coin-sensor lines, then detects coin insertions.
- Buffers accepted coins in a small FIFO and issues them as one-cycle `coin5`/`coin10` pulses, but only while the FSM signals it can take coins.
- Flags coins it must send to the return chute: FIFO full, or both sensors qualifying in the same cycle (jam).

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive synchronised cycles a sensor level must hold to count; legal values ≥2.
- `FIFO_DEPTH`, 4: coin buffer entries; power of 2, ≥2.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `coin5_raw`  in  1  raw 5-unit sensor, asynchronous, may bounce.
- `coin10_raw`  in  1  raw 10-unit sensor, asynchronous, may bounce.
- `accept`  in  1  downstream can take a coin. Driven high while the FSM is in its idle/partial-credit states, low while dispensing.
- `coin5`  out  1  one-cycle 5-unit coin pulse to the FSM.
- `coin10`  out  1  one-cycle 10-unit coin pulse to the FSM.
- `reject`  out  1  one-cycle pulse: coin qualified while the FIFO was full (see Operation for the push/pop exception); coin is not stored.
- `jam`  out  1  one-cycle pulse: both channels qualified in the same cycle; neither coin is stored.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
**Per-channel conditioning** (identical for each sensor):
- 2-flop synchroniser produces `s`.
- Channel FSM states: REARM, IDLE, QUAL_HI, HELD.
  - REARM: counts cycles with s=0. Any s=1 clears the count. After DEBOUNCE_CYCLES consecutive lows → IDLE.
  - IDLE: on s=1 → QUAL_HI, count=1.
  - QUAL_HI: on s=0 → IDLE (glitch, no event). When the count reaches DEBOUNCE_CYCLES with s=1 → HELD, and issue a one-cycle registered qualify pulse.
  - HELD: on s=0 → REARM. Exactly one event per insertion, regardless of how long the sensor is held.
- Reset state is REARM. A sensor stuck high through reset never produces a coin until it has been released for DEBOUNCE_CYCLES cycles and then re-asserted.

**Arbitration and push:**
- Exactly one qualify pulse: push the coin type (C5/C10).
- If the FIFO is full, pulse `reject` instead of pushing.
- Exception: a push in the same cycle as a pop while full is allowed; no reject.
- Both qualify pulses in the same cycle: pulse `jam`, push nothing, ignore `reject`.

**Pop:**
- When `accept`=1 and the FIFO is not empty (registered occupancy), drive the head type on `coin5`/`coin10` combinationally for that cycle and pop at the next edge.
- With `accept` held high, back-to-back coins pop on consecutive cycles.
- No bypass: a coin pushed at edge e is visible no earlier than the cycle after e.
- `coin5` and `coin10` are never high together, and are never high while `accept`=0.

**Counters and pointers:**
- FIFO pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- `level` saturates by construction at 0..FIFO_DEPTH.

**Reset:**
- All outputs 0, FIFO emptied, pointers 0, channels in REARM, synchronisers 0.
- Assertion mid-operation discards any buffered coins immediately, asynchronously.

## Timing
- Raw input sampled high first at edge k and held clean: qualify pulse registered at edge k+DEBOUNCE_CYCLES+1, pushed at that edge. The coin pulse is asserted in the following cycle if `accept`=1 and the FIFO was empty.
  - DEBOUNCE_CYCLES=4: first sample at edge 10 → push at edge 15 → `coin10` high during the cycle after edge 15.
- `reject`/`jam` are registered and high for exactly the one cycle after the qualifying edge.
- Minimum spacing between two events on one channel: 2×DEBOUNCE_CYCLES+1 cycles.
- After reset release with raws low, a channel is armed after DEBOUNCE_CYCLES edges.

## Structure
- Package `coin_pkg`: coin-type enum (NONE=2'b00, C5=2'b01, C10=2'b10) and channel-state enum (REARM, IDLE, QUAL_HI, HELD).
- Sub-module `coin_debounce`, instantiated twice. Contains the synchroniser and channel FSM; outputs the qualify pulse.
- Top `coin_acceptor` holds arbitration, FIFO and output logic.

## Test plan
- Reset, raws low, `accept`=1. Clean 10-unit insertion (first sampled edge 10, DEBOUNCE_CYCLES=4) → single `coin10` pulse in the cycle after edge 15; `level` returns to 0.
- `coin5_raw` bounces (high 2 cycles, low 1, high 10) → exactly one `coin5`. Only the final stable run qualifies.
- `accept`=0, five 5-unit coins inserted, FIFO_DEPTH=4 → `level`=4, fifth coin gives one `reject` pulse, no coin pulses. Then raise `accept` → four consecutive single-cycle `coin5` pulses, `level` 4→0.
- Both raws asserted on the same edge → one `jam` pulse, `level` unchanged, no coin pulse.
- FIFO full, `accept`=1, new coin qualifies in a pop cycle → no reject, `level` stays 4.
- `coin10_raw` held high through reset deassertion → no coin until it is released and reinserted. `rst_n` pulsed low with 3 buffered coins → `level`=0 immediately, and no pulses follow.
